// File: rtl/ahb_master_mux_n.sv
// ahb_master_mux_n
// Multi-master AHB-lite bus fabric slice: selects the address phase of the
// master granted by an external arbiter, decodes it onto a one-hot slave
// select, tracks the data phase, and muxes the slave responses back. Any
// address that decodes outside the mapped slaves goes to an internal default
// slave that answers active transfers with a two-cycle ERROR response and
// counts those errors in a saturating 8-bit counter.
//
// Ports
//   HCLK, HRESET            clock, synchronous active-high reset
//   HMASTER                 address-phase master id from the arbiter
//   HADDR_M .. HWDATA_M     per-master request buses, master i at slice i
//   HADDR .. HBURST         selected address-phase signals
//   HWDATA                  write data selected by the data-phase master
//   HSEL                    one-hot slave select (all zero = default slave)
//   HREADYOUT_S, HRESP_S,
//   HRDATA_S                per-slave responses, slave s at slice s
//   HREADY, HRESP, HRDATA   bus response returned to masters and slaves
//   HMASTER_D               data-phase master id
//   ERR_CNT                 saturating count of default-slave ERROR responses

module ahb_master_mux_n #(
    parameter int NM   = 2,
    parameter int NS   = 3,
    parameter int AW   = 14,
    parameter int DW   = 32,
    parameter int SELW = 2,
    parameter int MW   = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [MW-1:0]     HMASTER,
    input  logic [NM*AW-1:0]  HADDR_M,
    input  logic [NM-1:0]     HWRITE_M,
    input  logic [2*NM-1:0]   HTRANS_M,
    input  logic [3*NM-1:0]   HSIZE_M,
    input  logic [3*NM-1:0]   HBURST_M,
    input  logic [NM*DW-1:0]  HWDATA_M,
    output logic [AW-1:0]     HADDR,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DW-1:0]     HWDATA,
    output logic [NS-1:0]     HSEL,
    input  logic [NS-1:0]     HREADYOUT_S,
    input  logic [NS-1:0]     HRESP_S,
    input  logic [NS*DW-1:0]  HRDATA_S,
    output logic              HREADY,
    output logic              HRESP,
    output logic [DW-1:0]     HRDATA,
    output logic [MW-1:0]     HMASTER_D,
    output logic [7:0]        ERR_CNT
);

    typedef enum logic [1:0] {
        DS_OK,
        DS_ERR1,
        DS_ERR2
    } ds_state_t;

    ds_state_t       ds_state;
    ds_state_t       ds_next;
    logic [SELW-1:0] a_idx;
    logic            a_dflt;
    logic [SELW-1:0] d_idx;
    logic            d_dflt;
    logic            d_act;
    logic            ds_ready;
    logic            ds_resp;
    logic            err_start;

    // Address-phase mux. An out-of-range master id leaves everything at zero,
    // which is an IDLE transfer. Reset forces IDLE so nothing is started while
    // the fabric is being initialised.
    always_comb begin
        HADDR  = '0;
        HWRITE = 1'b0;
        HTRANS = 2'b00;
        HSIZE  = 3'b000;
        HBURST = 3'b000;
        for (int i = 0; i < NM; i++) begin
            if (int'(HMASTER) == i) begin
                HADDR  = HADDR_M[i*AW +: AW];
                HWRITE = HWRITE_M[i];
                HTRANS = HTRANS_M[2*i +: 2];
                HSIZE  = HSIZE_M[3*i +: 3];
                HBURST = HBURST_M[3*i +: 3];
            end
        end
        if (HRESET) begin
            HTRANS = 2'b00;
        end
    end

    // Slave decode from the top address bits; indices past the mapped slaves
    // fall through to the default slave.
    assign a_idx = HADDR[AW-1 -: SELW];

    always_comb begin
        HSEL   = '0;
        a_dflt = 1'b1;
        for (int s = 0; s < NS; s++) begin
            if (int'(a_idx) == s) begin
                HSEL[s] = 1'b1;
                a_dflt  = 1'b0;
            end
        end
    end

    // Data-phase tracking: captured only when the bus accepts the address
    // phase, so arbiter changes during wait states cannot disturb it.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HMASTER_D <= '0;
            d_idx     <= '0;
            d_dflt    <= 1'b1;
            d_act     <= 1'b0;
        end else if (HREADY) begin
            HMASTER_D <= HMASTER;
            d_idx     <= a_idx;
            d_dflt    <= a_dflt;
            d_act     <= HTRANS[1];
        end
    end

    // Write data follows the master that owns the current data phase.
    always_comb begin
        HWDATA = '0;
        for (int i = 0; i < NM; i++) begin
            if (int'(HMASTER_D) == i) begin
                HWDATA = HWDATA_M[i*DW +: DW];
            end
        end
    end

    // Default-slave state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ds_state <= DS_OK;
        end else begin
            ds_state <= ds_next;
        end
    end

    // Default-slave outputs, bus response mux and next state. These share one
    // block because the next state depends on HREADY, which in turn depends on
    // the default slave's own outputs; evaluating them in order here keeps the
    // dependency chain acyclic.
    always_comb begin
        ds_ready = 1'b1;
        ds_resp  = 1'b0;
        case (ds_state)
            DS_ERR1: begin
                ds_ready = 1'b0;
                ds_resp  = 1'b1;
            end
            DS_ERR2: begin
                ds_ready = 1'b1;
                ds_resp  = 1'b1;
            end
            default: begin
                ds_ready = 1'b1;
                ds_resp  = 1'b0;
            end
        endcase

        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        if (!d_dflt) begin
            for (int s = 0; s < NS; s++) begin
                if (int'(d_idx) == s) begin
                    HREADY = HREADYOUT_S[s];
                    HRESP  = HRESP_S[s];
                    HRDATA = HRDATA_S[s*DW +: DW];
                end
            end
        end else if (d_act) begin
            HREADY = ds_ready;
            HRESP  = ds_resp;
        end

        // An active transfer to an unmapped address accepted this cycle.
        err_start = HREADY && HTRANS[1] && a_dflt;

        ds_next = DS_OK;
        case (ds_state)
            DS_OK:   ds_next = err_start ? DS_ERR1 : DS_OK;
            DS_ERR1: ds_next = DS_ERR2;
            DS_ERR2: ds_next = err_start ? DS_ERR1 : DS_OK;
            default: ds_next = DS_OK;
        endcase
    end

    // One count per completed ERROR response, held at the top value.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ERR_CNT <= 8'h00;
        end else if (ds_state == DS_ERR2 && ERR_CNT != 8'hFF) begin
            ERR_CNT <= ERR_CNT + 8'h01;
        end
    end

endmodule

// File: doc/ahb_master_mux_n.md
AHB_MASTER_MUX_N -- requirements
Module: ahb_master_mux_n

Interface
REQ-001 The block SHALL have a single clock HCLK; reset is synchronous and active-high (HRESET), sampled only on the rising edge of HCLK.
REQ-002 Parameters SHALL be as follows (name, default, meaning):
- NM, 2: number of masters.
- NS, 3: number of mapped slaves; SELW must satisfy NS <= 2**SELW.
- AW, 14: address width.
- DW, 32: data width.
- SELW, 2: slave-select bits, taken as HADDR[AW-1 -: SELW].
- MW, $clog2(NM) with a minimum of 1: master-id width.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- HCLK, in, 1: clock.
- HRESET, in, 1: synchronous active-high reset.
- HMASTER, in, MW: address-phase master id from the arbiter.
- HADDR_M, in, NM*AW: master addresses; master i occupies [i*AW +: AW].
- HWRITE_M, in, NM: per-master write flag.
- HTRANS_M, in, 2*NM: per-master transfer type.
- HSIZE_M, in, 3*NM: per-master transfer size.
- HBURST_M, in, 3*NM: per-master burst type.
- HWDATA_M, in, NM*DW: per-master write data.
- HADDR/HWRITE/HTRANS/HSIZE/HBURST, out, AW/1/2/3/3: selected address-phase signals.
- HWDATA, out, DW: selected data-phase write data.
- HSEL, out, NS: one-hot slave select.
- HREADYOUT_S, in, NS: per-slave ready.
- HRESP_S, in, NS: per-slave response (1 = ERROR).
- HRDATA_S, in, NS*DW: per-slave read data.
- HREADY, out, 1: bus ready, returned to masters and slaves.
- HRESP, out, 1: bus response.
- HRDATA, out, DW: bus read data.
- HMASTER_D, out, MW: data-phase master id.
- ERR_CNT, out, 8: count of default-slave ERROR responses.

Function
REQ-004 Address-phase signals SHALL be selected combinationally by HMASTER, with zero latency.
REQ-005 If HMASTER >= NM, the address-phase outputs SHALL be all zero (HTRANS=IDLE).
REQ-006 While HRESET=1, HTRANS SHALL be forced to 2'b00 irrespective of HMASTER.
REQ-007 HMASTER_D SHALL load HMASTER on a rising edge where HREADY=1, and SHALL hold otherwise.
REQ-008 HWDATA SHALL be selected by HMASTER_D, or be zero if HMASTER_D >= NM.
REQ-009 Decode: for idx = HADDR[AW-1 -: SELW], HSEL[idx]=1 when idx < NS; otherwise HSEL is all zero and the transfer targets the internal default slave.
REQ-010 HSEL SHALL be combinational and independent of HTRANS.
REQ-011 Data-phase registers SHALL load on a rising edge with HREADY=1, and SHALL hold while HREADY=0. The registers are:
- d_idx (SELW bits).
- d_dflt: 1 if the transfer targets the default slave.
- d_act: HTRANS[1].
REQ-012 For a mapped data phase, the response SHALL be mux-driven: HREADY=HREADYOUT_S[d_idx], HRESP=HRESP_S[d_idx], HRDATA=HRDATA_S[d_idx].
REQ-013 The default slave SHALL be implemented as an FSM with states DS_OK, DS_ERR1 and DS_ERR2.
REQ-014 In DS_OK, when d_dflt=1 and d_act=0, the default slave SHALL drive HREADY=1, HRESP=0 and HRDATA=0 (zero-wait OKAY).
REQ-015 DS_OK SHALL go to DS_ERR1 on the cycle after a NONSEQ/SEQ address phase to an unmapped slave is accepted (HREADY=1).
REQ-016 In DS_ERR1 the default slave SHALL drive HREADY=0 and HRESP=1, then go unconditionally to DS_ERR2.
REQ-017 In DS_ERR2 the default slave SHALL drive HREADY=1 and HRESP=1, and SHALL return to DS_OK, or go to DS_ERR1 if another unmapped active transfer is accepted in that same cycle.
REQ-018 ERR_CNT SHALL increment by 1 on each DS_ERR2 cycle and saturate at 8'hFF, with no wrap.
REQ-019 A change of HMASTER while HREADY=0 SHALL alter the address-phase outputs only; the data-phase registers, HWDATA and the FSM are unaffected.
REQ-020 Back-to-back transfers SHALL pipeline: address phase N+1 overlaps data phase N, and response latency equals the slave's wait states.

Reset
REQ-021 On HRESET=1 at a rising edge, the block SHALL set:
- HMASTER_D=0, d_idx=0, d_dflt=1, d_act=0.
- FSM=DS_OK.
- ERR_CNT=0.
- Hence HREADY=1, HRESP=0, HRDATA=0.
REQ-022 HRESET asserted mid-error (DS_ERR1 or DS_ERR2) SHALL abort to DS_OK on the next edge, with no ERR_CNT increment.
REQ-023 Outputs SHALL be deterministic after the first reset edge; no reset-free state elements are permitted.

Verification
REQ-024 The bench SHALL cover the following directed scenarios, using defaults (NM=2, NS=3, AW=14):
- Master 1 NONSEQ write, HADDR_M[1]=14'h2004, HMASTER=1, HWDATA_M[1]=32'hA5A5_0001 -> HSEL=3'b100 the same cycle; the next cycle HWDATA=32'hA5A5_0001 and HMASTER_D=1.
- NONSEQ to 14'h3000 -> HSEL=0; then HREADY=0/HRESP=1 for one cycle, HREADY=1/HRESP=1 for one cycle, ERR_CNT=1.
- IDLE to 14'h3000 -> HREADY=1, HRESP=0, ERR_CNT unchanged.
- Slave 0 holds HREADYOUT_S[0]=0 for 3 cycles while HMASTER toggles 0->1 -> HMASTER_D, HWDATA and HRDATA source stay on master 0 and slave 0 until HREADY=1.
- 300 consecutive unmapped NONSEQ transfers -> ERR_CNT saturates at 8'hFF.
- HRESET=1 asserted during DS_ERR1 -> next edge HREADY=1, HRESP=0, ERR_CNT=0, HTRANS=2'b00 while reset is held.
